// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: skid FSM state encodings
// and the bubble control value driven whenever a slot holds no live instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int CTRL_NOP = 0;

endpackage

// File: rtl/pipe_bundle_reg.sv
// Data+control bundle register with load enable and asynchronous active-low reset.
module pipe_bundle_reg #(
  parameter int           W       = 40,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, flush and bubble gating.
// Define PIPE_SKID_EN for the 2-entry skid buffer with a registered o_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  localparam int              BW         = DATA_W + CTRL_W;
  localparam logic [BW-1:0]   BUNDLE_RST = {RST_DATA, CTRL_W'(CTRL_NOP)};

  pipe_state_e   state;
  pipe_state_e   next_state;
  logic          accept;
  logic          issue;
  logic          main_load;
  logic [BW-1:0] main_d;
  logic [BW-1:0] main_q;

  assign o_valid = (state != ST_EMPTY);
  assign accept  = i_valid & o_ready;
  assign issue   = o_valid & i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

`ifdef PIPE_SKID_EN
  logic          skid_load;
  logic [BW-1:0] skid_q;
  logic          ready_q;

  // Flush wins over every transition and drops any beat offered alongside it.
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) next_state = ST_BUSY;
        ST_BUSY: begin
          if (accept && !issue) begin
            next_state = ST_FULL;
          end else if (!accept && issue) begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL:  if (issue) next_state = ST_BUSY;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  // Main always presents the oldest beat; the skid entry catches the beat that
  // arrives while the downstream stage is stalled.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {i_data, i_ctrl};
    if (!i_flush) begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_BUSY: begin
          main_load = accept & issue;
          skid_load = accept & ~issue;
        end
        ST_FULL: begin
          main_load = issue;
          main_d    = skid_q;
        end
        default: main_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (next_state != ST_FULL);
    end
  end

  assign o_ready = ready_q;

  pipe_bundle_reg #(
    .W       (BW),
    .RST_VAL (BUNDLE_RST)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     ({i_data, i_ctrl}),
    .q     (skid_q)
  );
`else
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) next_state = ST_BUSY;
        ST_BUSY:  if (!accept && issue) next_state = ST_EMPTY;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  // With a single entry an accept can only happen when the slot is free or draining.
  always_comb begin
    main_load = 1'b0;
    main_d    = {i_data, i_ctrl};
    if (!i_flush) begin
      main_load = accept;
    end
  end

  assign o_ready = ~o_valid | i_ready;
`endif

  pipe_bundle_reg #(
    .W       (BW),
    .RST_VAL (BUNDLE_RST)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  assign o_data = main_q[BW-1:CTRL_W];
  assign o_ctrl = o_valid ? main_q[CTRL_W-1:0] : CTRL_W'(CTRL_NOP);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table-driven streaming plus hand-written
// back-pressure, flush and reset sequences, checked against a queue scoreboard.
module tb_pipe_stage_reg;

  localparam int          DATA_W   = 32;
  localparam int          CTRL_W   = 8;
  localparam logic [31:0] RST_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = '0;
  logic [7:0]  i_ctrl = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [7:0]  o_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  ctrl;
  } beat_t;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        flush;
    logic        exp_valid;
    logic        exp_ready;
  } vec_t;

  beat_t beat_q[$];
  beat_t last_front;
  vec_t  vecs[10];
  int    checks = 0;
  int    errors = 0;
  logic  obs_valid;
  logic  obs_ready;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_DATA (RST_DATA)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_ctrl  (i_ctrl),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_ctrl  (o_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ctrl_of(input logic [31:0] d);
    return d[7:0] ^ 8'hA5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    beat_q.delete();
    last_front = '{data: RST_DATA, ctrl: 8'h00};
  endtask

  // One cycle: drive inputs just after an edge, compare against the scoreboard
  // before the next edge, then advance the model by the handshake outcome.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                               input logic f, input string tag);
    logic exp_valid;
    logic exp_ready;
    logic acc;
    logic iss;
    i_valid = v;
    i_data  = d;
    i_ctrl  = ctrl_of(d);
    i_ready = r;
    i_flush = f;
    #3;
    exp_valid = (beat_q.size() != 0);
`ifdef PIPE_SKID_EN
    exp_ready = (beat_q.size() < 2);
`else
    exp_ready = !exp_valid || r;
`endif
    obs_valid = o_valid;
    obs_ready = o_ready;
    checkOutput({tag, ".o_valid"}, 32'(o_valid), 32'(exp_valid));
    checkOutput({tag, ".o_ready"}, 32'(o_ready), 32'(exp_ready));
    if (exp_valid) begin
      checkOutput({tag, ".o_data"}, o_data, beat_q[0].data);
      checkOutput({tag, ".o_ctrl"}, 32'(o_ctrl), 32'(beat_q[0].ctrl));
    end else begin
      checkOutput({tag, ".o_data_idle"}, o_data, last_front.data);
      checkOutput({tag, ".o_ctrl_bubble"}, 32'(o_ctrl), 32'h0);
    end
    acc = v && exp_ready && !f;
    iss = exp_valid && r && !f;
    if (f) begin
      beat_q.delete();
    end else begin
      if (iss) void'(beat_q.pop_front());
      if (acc) beat_q.push_back('{data: d, ctrl: ctrl_of(d)});
    end
    if (beat_q.size() != 0) last_front = beat_q[0];
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".o_valid"}, 32'(o_valid), 32'h0);
    checkOutput({tag, ".o_ctrl"}, 32'(o_ctrl), 32'h0);
    checkOutput({tag, ".o_data"}, o_data, RST_DATA);
    checkOutput({tag, ".o_ready"}, 32'(o_ready), 32'h1);
  endtask

  initial begin
    modelReset();

    // Reset held with an offered beat: nothing may be captured.
    reset   = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h7777_0001;
    i_ctrl  = 8'hFF;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("reset_hold0");
    @(posedge clk);
    #1;
    checkResetState("reset_hold1");
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, "post_reset_idle");

    // Streaming at full rate.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{valid: 1'b1, data: 32'(k + 1), ready: 1'b1, flush: 1'b0,
                  exp_valid: (k != 0), exp_ready: 1'b1};
    end
    vecs[8] = '{valid: 1'b0, data: 32'h0, ready: 1'b1, flush: 1'b0, exp_valid: 1'b1, exp_ready: 1'b1};
    vecs[9] = '{valid: 1'b0, data: 32'h0, ready: 1'b1, flush: 1'b0, exp_valid: 1'b0, exp_ready: 1'b1};
    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].valid, vecs[k].data, vecs[k].ready, vecs[k].flush, $sformatf("stream%0d", k));
      checkOutput($sformatf("stream%0d.tbl_valid", k), 32'(obs_valid), 32'(vecs[k].exp_valid));
      checkOutput($sformatf("stream%0d.tbl_ready", k), 32'(obs_ready), 32'(vecs[k].exp_ready));
    end

    // Back-pressure: 0xA held, 0xB offered while stalled, then drain.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, "bp_a");
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, "bp_b");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, "bp_hold");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain0");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain1");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "bp_empty");

    // Flush with a beat offered in the same cycle: nothing held may surface.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, "fl_a");
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, "fl_b");
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, "fl_c");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, $sformatf("fl_after%0d", k));
    end

    // Asynchronous reset in the middle of a cycle while a beat is held.
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, "ar_load");
    i_valid = 1'b0;
    reset   = 1'b0;
    #2;
    checkResetState("ar_mid");
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0, $sformatf("ar_resume%0d", k));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "ar_tail0");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "ar_tail1");

`ifdef PIPE_SKID_EN
    // Registered ready: a downstream release does not reopen o_ready in the same cycle.
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, "rr_a");
    applyStimulus(1'b1, 32'h67, 1'b0, 1'b0, "rr_b");
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    checkOutput("rr_same_cycle", 32'(o_ready), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "rr_drain0");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "rr_drain1");
`else
    // Combinational ready follows i_ready within the cycle.
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, "cr_load");
    i_valid = 1'b0;
    i_ready = 1'b0;
    #1;
    checkOutput("cr_stall", 32'(o_ready), 32'h0);
    i_ready = 1'b1;
    #1;
    checkOutput("cr_release", 32'(o_ready), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "cr_drain");
`endif

    // Mixed random traffic with stalls and occasional flushes.
    for (int k = 0; k < 120; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0), $sformatf("rnd%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, $sformatf("final%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
